// File: rtl/seq_divider.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, with start/ready request and valid/ack result handshakes.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             valid_out,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    count_q;
    logic             signQuot_q;
    logic             signRem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             divByZero_q;

    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] q_d;

    // Magnitudes and one restoring step: shift {A,Q} left, trial-subtract M, keep the result if non-negative.
    // A always stays below M (at most 2^(WIDTH-1)), so it is stored in WIDTH bits; the extra sign bit exists only in the trial.
    always_comb begin
        dividendMag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisorMag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        shifted     = {a_q, q_q[WIDTH-1]};
        trial       = shifted - {1'b0, m_q};
        a_d         = shifted[WIDTH-1:0];
        q_d         = {q_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            a_d    = trial[WIDTH-1:0];
            q_d[0] = 1'b1;
        end
    end

    // Control FSM and datapath registers; clear aborts to IDLE with everything zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            signQuot_q  <= 1'b0;
            signRem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            signQuot_q  <= 1'b0;
            signRem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            divByZero_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            q_q        <= dividendMag;
                            m_q        <= divisorMag;
                            a_q        <= '0;
                            count_q    <= '0;
                            signQuot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            signRem_q  <= dividend[WIDTH-1];
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q  <= signQuot_q ? (~q_q + 1'b1) : q_q;
                    remainder_q <= signRem_q ? (~a_q + 1'b1) : a_q;
                    divByZero_q <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign valid_out   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=16) with hand-computed expected results.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        ack;
    logic        ready;
    logic        busy;
    logic        valid_out;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ack         (ack),
        .ready       (ready),
        .busy        (busy),
        .valid_out   (valid_out),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge, scramble the operands afterwards, and wait for valid_out.
    // lat counts edges after the accepting edge; busyCnt counts samples with busy high.
    task automatic run_op(input logic [15:0] dd, input logic [15:0] dv,
                          output int lat, output int busyCnt, output bit timedOut);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 16'h0003;
        lat      = 0;
        busyCnt  = 0;
        timedOut = 1'b0;
        while (!valid_out && !timedOut) begin
            if (busy) busyCnt++;
            if (lat >= 40) timedOut = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    // Consume a result with a one-cycle ack pulse.
    task automatic ack_result();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (quotient !== 16'h0000) begin errors++; $display("[TB] FAIL reset_quotient got=%h exp=0000", quotient); end
        checks++; if (remainder !== 16'h0000) begin errors++; $display("[TB] FAIL reset_remainder got=%h exp=0000", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got=%b exp=0", div_by_zero); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int  lat;
        int  busyCnt;
        bit  to;
        ack = 1'b1;
        run_op(16'd100, 16'd7, lat, busyCnt, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout got=no valid exp=valid"); end
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL basic_latency got=%0d exp=17", lat); end
        checks++; if (busyCnt !== 17) begin errors++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=17", busyCnt); end
        checks++; if (quotient !== 16'd14) begin errors++; $display("[TB] FAIL basic_quotient got=%h exp=000e", quotient); end
        checks++; if (remainder !== 16'd2) begin errors++; $display("[TB] FAIL basic_remainder got=%h exp=0002", remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL basic_dbz got=%b exp=0", div_by_zero); end
        tick();
        ack = 1'b0;
        checks++; if (valid_out !== 1'b0 || ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_after_ack got=valid%b ready%b exp=valid0 ready1", valid_out, ready); end
        checks++; if (quotient !== 16'd14) begin errors++; $display("[TB] FAIL basic_hold_after_ack got=%h exp=000e", quotient); end
    endtask

    task automatic test_signs_and_corners();
        logic [15:0] vecDd [7] = '{16'hFF9C, 16'd100, 16'hFF9C, 16'd7, 16'h8000, 16'h8000, 16'h7FFF};
        logic [15:0] vecDv [7] = '{16'd7, 16'hFFF9, 16'hFFF9, 16'd100, 16'hFFFF, 16'h0001, 16'h7FFF};
        logic [15:0] vecQ  [7] = '{16'hFFF2, 16'hFFF2, 16'h000E, 16'h0000, 16'h8000, 16'h8000, 16'h0001};
        logic [15:0] vecR  [7] = '{16'hFFFE, 16'h0002, 16'hFFFE, 16'h0007, 16'h0000, 16'h0000, 16'h0000};
        int  lat;
        int  busyCnt;
        bit  to;
        for (int i = 0; i < 7; i++) begin
            run_op(vecDd[i], vecDv[i], lat, busyCnt, to);
            checks++; if (to || lat !== 17) begin errors++; $display("[TB] FAIL vec%0d_latency got=%0d exp=17", i, lat); end
            checks++; if (quotient !== vecQ[i]) begin errors++; $display("[TB] FAIL vec%0d_quotient got=%h exp=%h", i, quotient, vecQ[i]); end
            checks++; if (remainder !== vecR[i]) begin errors++; $display("[TB] FAIL vec%0d_remainder got=%h exp=%h", i, remainder, vecR[i]); end
            checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL vec%0d_dbz got=%b exp=0", i, div_by_zero); end
            ack_result();
        end
    endtask

    task automatic test_div_by_zero();
        int  lat;
        int  busyCnt;
        bit  to;
        run_op(16'd1234, 16'd0, lat, busyCnt, to);
        checks++; if (to || lat !== 0) begin errors++; $display("[TB] FAIL dbz_latency got=%0d exp=0 edges after accept", lat); end
        checks++; if (quotient !== 16'hFFFF) begin errors++; $display("[TB] FAIL dbz_quotient got=%h exp=ffff", quotient); end
        checks++; if (remainder !== 16'h04D2) begin errors++; $display("[TB] FAIL dbz_remainder got=%h exp=04d2", remainder); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag got=%b exp=1", div_by_zero); end
        ack_result();
        run_op(16'd10, 16'd3, lat, busyCnt, to);
        checks++; if (to || lat !== 17) begin errors++; $display("[TB] FAIL after_dbz_latency got=%0d exp=17", lat); end
        checks++; if (quotient !== 16'd3 || remainder !== 16'd1) begin errors++; $display("[TB] FAIL after_dbz_result got=%h/%h exp=0003/0001", quotient, remainder); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL after_dbz_flag got=%b exp=0", div_by_zero); end
        ack_result();
    endtask

    task automatic test_handshake();
        int waitCnt;
        dividend = 16'd1000;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        repeat (3) tick();
        dividend = 16'd5;
        divisor  = 16'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        waitCnt  = 0;
        while (!valid_out && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checks++; if (!valid_out) begin errors++; $display("[TB] FAIL hs_timeout got=no valid exp=valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dividend = 16'd9;
                divisor  = 16'd2;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            checks++; if (valid_out !== 1'b1 || ready !== 1'b0) begin errors++; $display("[TB] FAIL hs_hold%0d got=valid%b ready%b exp=valid1 ready0", i, valid_out, ready); end
            checks++; if (quotient !== 16'd142 || remainder !== 16'd6) begin errors++; $display("[TB] FAIL hs_result%0d got=%h/%h exp=008e/0006", i, quotient, remainder); end
        end
        start = 1'b0;
        ack_result();
        checks++; if (ready !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("[TB] FAIL hs_after_ack got=ready%b valid%b exp=ready1 valid0", ready, valid_out); end
    endtask

    task automatic test_abort();
        int  lat;
        int  busyCnt;
        bit  to;
        bit  sawValid;
        // Asynchronous reset mid-calculation; previous results are nonzero so zeroing is observable.
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_abort_state got=ready%b busy%b exp=ready1 busy0", ready, busy); end
        checks++; if (quotient !== 16'h0 || remainder !== 16'h0) begin errors++; $display("[TB] FAIL rst_abort_outputs got=%h/%h exp=0000/0000", quotient, remainder); end
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_out) sawValid = 1'b1;
        end
        checks++; if (sawValid) begin errors++; $display("[TB] FAIL rst_abort_no_valid got=valid seen exp=none"); end
        run_op(16'd50, 16'd5, lat, busyCnt, to);
        checks++; if (to || quotient !== 16'd10 || remainder !== 16'd0) begin errors++; $display("[TB] FAIL rst_followup got=%h/%h exp=000a/0000", quotient, remainder); end
        ack_result();
        // Synchronous clear for one cycle mid-calculation.
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("[TB] FAIL clr_abort_state got=ready%b busy%b valid%b exp=ready1 busy0 valid0", ready, busy, valid_out); end
        checks++; if (quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL clr_abort_outputs got=%h/%h/%b exp=0000/0000/0", quotient, remainder, div_by_zero); end
        sawValid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_out) sawValid = 1'b1;
        end
        checks++; if (sawValid) begin errors++; $display("[TB] FAIL clr_abort_no_valid got=valid seen exp=none"); end
        run_op(16'd50, 16'd5, lat, busyCnt, to);
        checks++; if (to || lat !== 17) begin errors++; $display("[TB] FAIL clr_followup_latency got=%0d exp=17", lat); end
        checks++; if (quotient !== 16'd10 || remainder !== 16'd0) begin errors++; $display("[TB] FAIL clr_followup got=%h/%h exp=000a/0000", quotient, remainder); end
        ack_result();
    endtask

    // Test sequence.
    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        ack      = 1'b0;
        dividend = 16'h0;
        divisor  = 16'h0;
        test_reset();
        test_basic();
        test_signs_and_corners();
        test_div_by_zero();
        test_handshake();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
